// File: rtl/inst_loader_pkg.sv
// Shared types for the instruction loader.
// State encoding and instruction-memory geometry.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam int IMEM_ADDR_W = 8;

endpackage

// File: rtl/inst_loader_if.sv
// Byte stream in, instruction-memory write port out.
// The loader takes the slave side.
interface inst_loader_if
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

// File: rtl/inst_loader_timeout.sv
// Clearable saturating idle-cycle counter.
// Flags expiry once TIMEOUT cycles pass; 0 disables it.
module loader_timeout #(
  parameter int TIMEOUT = 1000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIM = W'(TIMEOUT);

  logic [W-1:0] cnt_q;

  // count idle cycles, saturating at the limit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && cnt_q != LIM) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == LIM);

endmodule

// File: rtl/inst_loader.sv
// Byte-stream instruction image loader.
// Holds the CPU in reset while filling instruction memory.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int TIMEOUT   = 1000000,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load_start,
  inst_loader_if.slave  bus,
  output logic          cpu_rst,
  output logic          busy,
  output logic          load_done,
  output logic          load_err,
  output logic [ADDR_W:0] words_loaded
);

  localparam int TW = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL =
    {1'b1, {ADDR_W{1'b0}}};

  state_e state_q, state_d;

  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   target_q;
  logic [1:0]        idx_q;

  logic xfer;
  logic start;
  logic expired;
  logic last_word;
  logic tmo_en;

  assign xfer      = bus.byte_valid && ready_q;
  assign last_word = (words_q + 1'b1) == target_q;
  assign tmo_en    = (state_q == S_HDR) ||
                     (state_q == S_DATA);

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (start || xfer),
    .en      (tmo_en),
    .expired (expired)
  );

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state decode and load-start detection
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_start) begin
          start   = 1'b1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (xfer)         state_d = S_DATA;
        else if (expired) state_d = S_ERR;
      end
      S_DATA: begin
        if (xfer) begin
          if (idx_q == 2'd3) state_d = S_WRITE;
        end else if (expired) begin
          state_d = S_ERR;
        end
      end
      S_WRITE: begin
        state_d = last_word ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // registered status outputs follow the next state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      cpu_rst   <= BOOT_HOLD;
    end else begin
      ready_q   <= (state_d == S_HDR) ||
                   (state_d == S_DATA);
      we_q      <= (state_d == S_WRITE);
      busy      <= (state_d == S_HDR)  ||
                   (state_d == S_DATA) ||
                   (state_d == S_WRITE);
      load_done <= (state_d == S_DONE);
      load_err  <= (state_d == S_ERR);
      unique case (1'b1)
        (state_d == S_DONE): cpu_rst <= 1'b0;
        (state_d == S_IDLE): cpu_rst <= BOOT_HOLD;
        default:             cpu_rst <= 1'b1;
      endcase
    end
  end

  // word assembly, header latch and address counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      words_q  <= '0;
      target_q <= '0;
      idx_q    <= '0;
    end else if (start) begin
      addr_q  <= '0;
      words_q <= '0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        S_HDR: begin
          if (xfer) begin
            target_q <= (bus.byte_data == 8'd0) ?
                        FULL : TW'(bus.byte_data);
          end
        end
        S_DATA: begin
          if (xfer) begin
            wdata_q <= {wdata_q[23:0], bus.byte_data};
            idx_q   <= idx_q + 2'd1;
          end
        end
        S_WRITE: begin
          words_q <= words_q + 1'b1;
          addr_q  <= addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign words_loaded   = words_q;

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction-memory port: receives a byte stream (valid/ready), assembles big-endian 32-bit words and writes them sequentially into the 256-word instruction memory.
- Holds the CPU in reset while loading and releases it when the image is complete.
- Sits between the board-level byte source (UART receiver / debug bridge) and the instruction memory write port plus the CPU reset input.

Parameters:
- ADDR_W, 8, instruction memory word-address width (depth 2^ADDR_W).
- TIMEOUT, 1000000, max CLK cycles allowed between accepted bytes while loading; 0 disables the timeout.
- BOOT_HOLD, 1, 1 = keep cpu_rst high from RST until the first successful load; 0 = cpu_rst low when idle.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- load_start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- mem_we  out  1  instruction memory write enable, one cycle per word.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  word to write.
- cpu_rst  out  1  reset to CPU, active-high.
- busy  out  1  high in HDR, DATA and WRITE.
- load_done  out  1  high in DONE until next load_start or RST.
- load_err  out  1  high in ERR until next load_start or RST.
- words_loaded  out  ADDR_W+1  count of words written in current/last load.

Behaviour:
- Reset values:
  - State IDLE.
  - byte_ready, mem_we, busy, load_done and load_err = 0.
  - mem_addr, mem_wdata and words_loaded = 0.
  - cpu_rst = BOOT_HOLD.
- Handshake: a byte transfers on a rising edge where byte_valid && byte_ready. The source must hold byte_data stable while valid && !ready. byte_ready is registered and high only in HDR and DATA.
- Load format:
  - One header byte N = word count; N == 0 means 2^ADDR_W words.
  - Followed by 4*N data bytes, MSB first: the first byte goes to mem_wdata[31:24].
- IDLE: on load_start, go to HDR. Clear words_loaded, mem_addr, byte index and timeout counter. Set cpu_rst = 1.
- HDR: on transfer, latch N into the target count and go to DATA.
- DATA:
  - Each transfer shifts the byte into the word assembly register and increments the 2-bit byte index.
  - On the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - mem_we = 1, mem_addr = current word address, mem_wdata = assembled word, byte_ready = 0.
  - Next edge: words_loaded += 1 and mem_addr += 1; mem_addr wraps at 2^ADDR_W, which is reachable only when N == 0.
  - If words_loaded+1 == target, go to DONE; else go to DATA.
- Sustained throughput: 4 data bytes per 5 cycles.
- DONE: cpu_rst = 0 and load_done = 1. The CPU begins fetching at PC 0 on the first edge after release.
- ERR: cpu_rst = 1 and load_err = 1. The partial image stays in memory and the CPU stays held.
- Timeout:
  - The counter increments each cycle in HDR/DATA and clears on every transfer.
  - When it reaches TIMEOUT, go to ERR.
  - It does not count in WRITE.
- load_start in HDR/DATA/WRITE is ignored. load_start in DONE/ERR restarts a load, equivalent to IDLE behaviour.
- RST mid-load: immediate return to reset values. Memory contents already written are left as is.
- mem_we is never asserted outside WRITE. No byte is accepted in the same cycle as a write.

Decomposition:
- Shared package: state encoding constants (IDLE, HDR, DATA, WRITE, DONE, ERR) and the memory depth constant shared with inst_mem (ADDR_W = 8).
- One natural sub-module: loader_timeout, a clearable saturating cycle counter with an expiry flag (TIMEOUT parameter).
- The FSM, word assembly and address counter stay in inst_loader.

Test Plan:
- RST, then 10 idle cycles -> cpu_rst = 1 (BOOT_HOLD = 1), byte_ready = 0, mem_we = 0, all counters 0.
- load_start, bytes 02, 20,01,00,05, 00,22,18,20 sent back-to-back -> two mem_we pulses: addr 0 data 0x20010005, then addr 1 data 0x00221820. Then load_done = 1, cpu_rst = 0, words_loaded = 2.
- Same load with byte_valid toggled randomly -> identical writes; no byte lost or duplicated; byte_ready = 0 during each WRITE cycle.
- Header 00 followed by 1024 bytes -> 256 writes at addresses 0..255, mem_addr wraps to 0, words_loaded = 256, load_done = 1.
- TIMEOUT = 20, stall after 3 data bytes -> ERR after 20 idle cycles: load_err = 1, cpu_rst = 1, no write for the partial word. Then load_start with a valid image -> load_done = 1.
- RST asserted asynchronously mid-DATA -> outputs return to reset values without waiting for a clock edge. load_start pulsed during a load -> ignored, counters unaffected.
